// File: rtl/rr_arb_pkg.sv
// Shared arbiter-side definitions: default requester count, grant-mux FSM states
// and a one-hot check used on the incoming grant vector.
package rr_arb_pkg;

  localparam int NREQ_DEF = 4;

  typedef enum logic {
    IDLE = 1'b0,
    FULL = 1'b1
  } state_t;

  // Callers zero-extend their grant vector to 32 bits; requester counts stay well below that.
  function automatic logic onehot_is_valid(input logic [31:0] v);
    return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
  endfunction

endpackage

// File: rtl/onehot_to_idx.sv
// One-hot to binary index encoder; combinational, no backpressure.
// An all-zero input encodes to 0; multi-hot inputs are screened out upstream.
module onehot_to_idx #(
  parameter int NREQ  = 4,
  parameter int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  onehot,
  output logic [IDX_W-1:0] idx
);

  always_comb begin
    idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (onehot[i]) idx = idx | i[IDX_W-1:0];
    end
  end

endmodule

// File: rtl/rr_grant_mux.sv
// Grant-driven payload mux into one valid/ready register slice; 1-cycle capture-to-valid/ack,
// a stalled slice ignores grants. Optional per-requester ack counters under RR_GRANT_MUX_PERF_CNT_EN.
module rr_grant_mux
  import rr_arb_pkg::*;
#(
  parameter  int NREQ   = NREQ_DEF,
  parameter  int DATA_W = 32,
  localparam int IDX_W  = $clog2(NREQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        gnt,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*DATA_W-1:0] req_data,
  output logic [NREQ-1:0]        req_ack,
  output logic                   out_valid,
  output logic [DATA_W-1:0]      out_data,
  output logic [IDX_W-1:0]       out_src,
  input  logic                   out_ready,
  output logic                   gnt_err
`ifdef RR_GRANT_MUX_PERF_CNT_EN
  ,
  output logic [NREQ*16-1:0]     perf_cnt
`endif
);

  state_t             state;
  logic [IDX_W-1:0]   gnt_idx;
  logic [DATA_W-1:0]  sel_data;
  logic               gnt_1h;
  logic               gnt_multi;
  logic               eligible;
  logic               slot_free;
  logic               take;

  onehot_to_idx #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_enc (
    .onehot (gnt),
    .idx    (gnt_idx)
  );

  assign sel_data  = req_data[gnt_idx*DATA_W +: DATA_W];
  assign gnt_1h    = onehot_is_valid(32'(gnt));
  assign gnt_multi = (gnt != '0) && !gnt_1h;
  assign eligible  = gnt_1h && ((gnt & req_valid) != '0);
  assign slot_free = (state == IDLE) || (out_valid && out_ready);
  assign take      = eligible && slot_free;
  assign out_valid = (state == FULL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      out_data <= '0;
      out_src  <= '0;
      req_ack  <= '0;
      gnt_err  <= 1'b0;
    end else begin
      // Ack mirrors the grant only in the capture cycle, so it can never stretch.
      req_ack <= take ? gnt : '0;
      if (gnt_multi) gnt_err <= 1'b1;
      if (take) begin
        state    <= FULL;
        out_data <= sel_data;
        out_src  <= gnt_idx;
      end else if ((state == FULL) && out_ready) begin
        state <= IDLE;
      end
    end
  end

`ifdef RR_GRANT_MUX_PERF_CNT_EN
  logic [15:0] ack_cnt [NREQ];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREQ; i++) ack_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (req_ack[i] && (ack_cnt[i] != 16'hFFFF)) ack_cnt[i] <= ack_cnt[i] + 16'd1;
      end
    end
  end

  for (genvar g = 0; g < NREQ; g++) begin : g_cnt_out
    assign perf_cnt[g*16 +: 16] = ack_cnt[g];
  end
`endif

endmodule

// File: tb/tb_rr_grant_mux.sv
// Randomised and directed stimulus against a requester-level reference model; a negedge
// monitor pops per-cycle and per-beat expectations from queues and compares.
module tb_rr_grant_mux;

  localparam int N  = 4;
  localparam int DW = 32;

  typedef struct {
    logic [N-1:0] ack;
    logic         valid;
    logic         err;
  } cyc_exp_t;

  typedef struct {
    logic [DW-1:0] data;
    logic [1:0]    src;
  } beat_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    gnt;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ack;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic [1:0]      out_src;
  logic            out_ready;
  logic            gnt_err;
`ifdef RR_GRANT_MUX_PERF_CNT_EN
  logic [N*16-1:0] perf_cnt;
`endif

  rr_grant_mux #(.NREQ(N), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .gnt       (gnt),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ack   (req_ack),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready),
    .gnt_err   (gnt_err)
`ifdef RR_GRANT_MUX_PERF_CNT_EN
    ,
    .perf_cnt  (perf_cnt)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: requester mailboxes plus the occupancy of the single output slot.
  bit            pend [N];
  logic [DW-1:0] pdat [N];
  bit            m_full;
  bit            m_err;
  int            m_cnt [N];

  cyc_exp_t cyc_q[$];
  beat_t    beat_q[$];
  bit       mon_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: one per-cycle expectation per negedge, one beat per output handshake.
  bit            prev_hold = 1'b0;
  logic [DW-1:0] prev_data;
  logic [1:0]    prev_src;
  always @(negedge clk) begin
    if (mon_en) begin
      cyc_exp_t e;
      if (cyc_q.size() == 0) begin
        chk("cyc_queue_underflow", 1, 0);
      end else begin
        e = cyc_q.pop_front();
        chk("req_ack", 64'(req_ack), 64'(e.ack));
        chk("out_valid", 64'(out_valid), 64'(e.valid));
        chk("gnt_err", 64'(gnt_err), 64'(e.err));
      end
      if (out_valid && prev_hold) begin
        chk("stall_data_stable", 64'(out_data), 64'(prev_data));
        chk("stall_src_stable", 64'(out_src), 64'(prev_src));
      end
      if (out_valid && out_ready) begin
        beat_t b;
        if (beat_q.size() == 0) begin
          chk("beat_queue_underflow", 1, 0);
        end else begin
          b = beat_q.pop_front();
          chk("beat_data", 64'(out_data), 64'(b.data));
          chk("beat_src", 64'(out_src), 64'(b.src));
        end
      end
      prev_hold = out_valid && !out_ready;
      prev_data = out_data;
      prev_src  = out_src;
    end
  end

  // Drive one cycle's inputs, predict the coming edge, then advance to posedge+2.
  task automatic cyc(input logic [N-1:0] g, input logic rdy);
    cyc_exp_t e;
    int gi;
    bit cap;
    gnt       = g;
    out_ready = rdy;
    for (int i = 0; i < N; i++) begin
      req_valid[i]          = pend[i];
      req_data[i*DW +: DW]  = pdat[i];
    end
    cap = 1'b0;
    gi  = 0;
    if ($countones(g) == 1) begin
      for (int i = 0; i < N; i++) if (g[i]) gi = i;
      cap = pend[gi] && (!m_full || rdy);
    end else if ($countones(g) > 1) begin
      m_err = 1'b1;
    end
    e.ack = cap ? g : '0;
    if (cap) begin
      beat_t b;
      b.data = pdat[gi];
      b.src  = 2'(gi);
      beat_q.push_back(b);
      m_full   = 1'b1;
      pend[gi] = 1'b0;
      if (m_cnt[gi] < 16'hFFFF) m_cnt[gi]++;
    end else if (m_full && rdy) begin
      m_full = 1'b0;
    end
    e.valid = m_full;
    e.err   = m_err;
    cyc_q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    cyc_exp_t e;
    mon_en    = 1'b0;
    gnt       = '0;
    out_ready = 1'b0;
    rst_n     = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_out_data", 64'(out_data), 0);
    chk("rst_out_src", 64'(out_src), 0);
    chk("rst_req_ack", 64'(req_ack), 0);
    chk("rst_gnt_err", 64'(gnt_err), 0);
    cyc_q.delete();
    beat_q.delete();
    m_full    = 1'b0;
    m_err     = 1'b0;
    prev_hold = 1'b0;
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    e.ack   = '0;
    e.valid = 1'b0;
    e.err   = 1'b0;
    cyc_q.push_back(e);
    mon_en = 1'b1;
  endtask

  initial begin
    int ptr;
    logic [N-1:0] g;
    rst_n     = 1'b0;
    gnt       = '0;
    req_valid = '0;
    req_data  = '0;
    out_ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b0;
      pdat[i] = '0;
    end
    @(posedge clk);
    #2;
    do_reset();

    // Single request from requester 1.
    pend[1] = 1'b1; pdat[1] = 32'hA5A5_0001;
    cyc(4'b0010, 1'b1);
    cyc(4'b0000, 1'b1);
    cyc(4'b0000, 1'b1);

    // Back-pressure on a beat from requester 2 while the grant keeps rotating.
    pend[2] = 1'b1; pdat[2] = 32'hB0B0_0002;
    cyc(4'b0100, 1'b1);
    pend[3] = 1'b1; pdat[3] = 32'hB0B0_0003;
    pend[0] = 1'b1; pdat[0] = 32'hB0B0_0000;
    pend[1] = 1'b1; pdat[1] = 32'hB0B0_0001;
    cyc(4'b1000, 1'b0);
    cyc(4'b0001, 1'b0);
    cyc(4'b0010, 1'b0);
    cyc(4'b1000, 1'b1);
    cyc(4'b0000, 1'b1);

    // Streaming: every requester valid, grant rotating 0..3.
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b1;
      pdat[i] = 32'hC0DE_0000 | 32'(i);
    end
    for (int i = 0; i < N; i++) cyc(4'(1 << i), 1'b1);
    cyc(4'b0000, 1'b1);

    // Reset while a beat is stalled in the slot, then a normal capture.
    pend[3] = 1'b1; pdat[3] = 32'hDEAD_0003;
    cyc(4'b1000, 1'b0);
    chk("pre_reset_valid", 64'(out_valid), 1);
    do_reset();
    pend[3] = 1'b1;
    pend[0] = 1'b1; pdat[0] = 32'h1234_5670;
    cyc(4'b0001, 1'b1);
    cyc(4'b0000, 1'b1);

    // Multi-hot grant: no capture, sticky error.
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b1;
      pdat[i] = 32'hE000_0000 | 32'(i);
    end
    cyc(4'b0101, 1'b1);
    for (int k = 0; k < 11; k++) cyc(4'b0000, 1'b1);

    // Randomised traffic with a rotating arbiter and random back-pressure.
    ptr = 0;
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && ($urandom_range(0, 2) == 0)) begin
          pend[i] = 1'b1;
          pdat[i] = $urandom;
        end
      end
      case ($urandom_range(0, 9))
        0:       g = '0;
        1:       g = 4'(1 << $urandom_range(0, N - 1));
        default: g = 4'(1 << ptr);
      endcase
      ptr = (ptr + 1) % N;
      cyc(g, $urandom_range(0, 3) != 0);
    end

`ifdef RR_GRANT_MUX_PERF_CNT_EN
    for (int k = 0; k < 70000; k++) begin
      pend[3] = 1'b1;
      pdat[3] = 32'(k);
      cyc(4'b1000, 1'b1);
    end
    cyc(4'b0000, 1'b1);
    chk("perf_cnt3_sat", 64'(perf_cnt[3*16 +: 16]), 64'h FFFF);
    for (int i = 0; i < N - 1; i++) chk("perf_cnt", 64'(perf_cnt[i*16 +: 16]), 64'(m_cnt[i]));
`endif

    for (int k = 0; k < 3; k++) cyc(4'b0000, 1'b1);
    chk("beats_drained", 64'(beat_q.size()), 0);
    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
